sum_result_fifo: RTL and testbench

- Downstream stage of the 16-bit adder block. Captures its 32-bit result word `{tag[15:0], sum[15:0]}`.
- Checks the upper-half tag against the expected fill pattern.
- Buffers the sum and a tag-ok flag in a small FIFO, then hands entries to the AXI-lite register/readout logic over a valid/ready handshake.
- Also keeps status counters so software can detect malformed or dropped results.

---
 rtl/sum_result_fifo.sv | 146 ++++++++++++++
 tb/tb_sum_result_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_result_fifo.sv
`default_nettype none
//============================================================================
// Module      : sum_result_fifo
// Description : Capture stage behind the 16-bit adder. It accepts the 32-bit
//               result word {tag[15:0], sum[15:0]} and checks the tag against
//               TAG. The sum and a tag-ok flag go into a first-word-fall-through
//               FIFO, which drains to the readout logic over valid/ready.
//               A saturating bad-tag counter and a sticky drop flag tell
//               software about malformed or lost results.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : asynchronous active-high reset
//   clr        : synchronous flush of FIFO, counters and sticky flag
//   in_valid   : in_data carries a result to capture
//   in_data    : [31:16] tag, [15:0] sum
//   in_ready   : FIFO can accept (not full)
//   out_valid  : head entry present (not empty)
//   out_ready  : consumer takes the head entry
//   out_sum    : sum field of the head entry
//   out_tag_ok : head entry's tag matched TAG
//   level      : current entry count, 0..DEPTH
//   err_count  : accepted words with a bad tag, saturating at all-ones
//   drop       : sticky, a word was offered while the FIFO was full
//============================================================================
module sum_result_fifo #(
    parameter int          DEPTH  = 8,
    parameter int          ADDR_W = 3,
    parameter logic [15:0] TAG    = 16'hFFFF,
    parameter int          ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_sum,
    output logic              out_tag_ok,
    output logic [ADDR_W:0]   level,
    output logic [ERR_W-1:0]  err_count,
    output logic              drop
);

    localparam logic [ADDR_W:0]   C_FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_LEVEL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE    = ADDR_W'(1);
    localparam logic [ERR_W-1:0]  C_ERR_ONE    = ERR_W'(1);

    // Storage: {tag_ok, sum}. Deliberately not reset; pointers and level
    // alone decide which entries are live.
    logic [16:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic              drop_q, drop_d;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;
    logic w_tag_ok;

    // Full/empty come from the registered level only, so the handshake
    // outputs have no combinational path from in_valid or out_ready, and
    // an asynchronous reset drives them to their idle values at once.
    assign w_full   = (level_q == C_FULL_LEVEL);
    assign w_empty  = (level_q == '0);
    assign w_tag_ok = (in_data[31:16] == TAG);

    // clr wins over any transfer in the same cycle.
    assign w_wr_en = in_valid && !w_full && !clr;
    assign w_rd_en = out_ready && !w_empty && !clr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        err_count_d = err_count_q;
        drop_d      = drop_q;

        if (clr) begin
            // Pointers are re-aligned to zero; memory contents are left as-is.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            err_count_d = '0;
            drop_d      = 1'b0;
        end else begin
            if (w_wr_en) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                if (!w_tag_ok && (err_count_q != '1)) begin
                    err_count_d = err_count_q + C_ERR_ONE;
                end
            end
            if (w_rd_en) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   level_d = level_q + C_LEVEL_ONE;
                2'b01:   level_d = level_q - C_LEVEL_ONE;
                default: level_d = level_q;
            endcase
            if (in_valid && w_full) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            err_count_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            err_count_q <= err_count_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[wr_ptr_q] <= {w_tag_ok, in_data[15:0]};
        end
    end

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign out_sum    = mem[rd_ptr_q][15:0];
    assign out_tag_ok = mem[rd_ptr_q][16];
    assign level      = level_q;
    assign err_count  = err_count_q;
    assign drop       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_result_fifo.sv
`default_nettype none
//============================================================================
// Module      : tb_sum_result_fifo
// Description : Self-checking bench for sum_result_fifo: a vector table,
//               hand-written corner sequences and randomized traffic checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_sum_result_fifo;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_tag_ok;
    logic [3:0]  level;
    logic [7:0]  err_count;
    logic        drop;

    sum_result_fifo #(
        .DEPTH (8),
        .ADDR_W(3),
        .TAG   (16'hFFFF),
        .ERR_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag_ok(out_tag_ok),
        .level     (level),
        .err_count (err_count),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of {tag_ok, sum}, a saturating counter
    // and a sticky flag.
    logic [16:0] m_q[$];
    int          m_err  = 0;
    logic        m_drop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_err  = 0;
        m_drop = 1'b0;
    endtask

    // One clock cycle with model checking: handshake/head before the edge,
    // registered status after it.
    task automatic cycle(input logic v, input logic [31:0] d, input logic ordy, input logic c);
        logic m_rdy, m_ovl;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        #1;
        m_rdy = (m_q.size() < 8);
        m_ovl = (m_q.size() > 0);
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ovl});
        if (m_ovl) begin
            chk("out_sum", {16'b0, out_sum}, {16'b0, m_q[0][15:0]});
            chk("out_tag_ok", {31'b0, out_tag_ok}, {31'b0, m_q[0][16]});
        end
        if (c) begin
            model_reset();
        end else begin
            if (v && !m_rdy) m_drop = 1'b1;
            if (m_ovl && ordy) void'(m_q.pop_front());
            if (v && m_rdy) begin
                m_q.push_back({d[31:16] == 16'hFFFF, d[15:0]});
                if (d[31:16] != 16'hFFFF && m_err < 255) m_err++;
            end
        end
        @(posedge clk);
        #1;
        chk("level", {28'b0, level}, m_q.size());
        chk("err_count", {24'b0, err_count}, m_err);
        chk("drop", {31'b0, drop}, {31'b0, m_drop});
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ordy;
        logic        c;
        logic        e_valid;
        logic [15:0] e_sum;
        logic        e_ok;
        logic [3:0]  e_level;
        logic [7:0]  e_err;
        logic        e_drop;
    } vec_t;

    vec_t tbl[6];

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_level", {28'b0, level}, 32'd0);
        chk("reset_err", {24'b0, err_count}, 32'd0);
        chk("reset_drop", {31'b0, drop}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- vector table: fall-through latency and tag check ----
        tbl[0] = '{1'b1, 32'hFFFF_1234, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 4'd1, 8'd0, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_00AA, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 4'd2, 8'd1, 1'b0};
        tbl[2] = '{1'b1, 32'hFFFF_00BB, 1'b1, 1'b0, 1'b1, 16'h00AA, 1'b0, 4'd2, 8'd1, 1'b0};
        tbl[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 16'h00BB, 1'b1, 4'd1, 8'd1, 1'b0};
        tbl[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 16'h0,    1'b0, 4'd0, 8'd1, 1'b0};
        tbl[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 4'd0, 8'd0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; out_ready = tbl[i].ordy; clr = tbl[i].c;
            @(posedge clk);
            #1;
            chk("tbl_out_valid", {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
            chk("tbl_in_ready", {31'b0, in_ready}, {31'b0, tbl[i].e_level != 4'd8});
            chk("tbl_level", {28'b0, level}, {28'b0, tbl[i].e_level});
            chk("tbl_err", {24'b0, err_count}, {24'b0, tbl[i].e_err});
            chk("tbl_drop", {31'b0, drop}, {31'b0, tbl[i].e_drop});
            if (tbl[i].e_valid) begin
                chk("tbl_sum", {16'b0, out_sum}, {16'b0, tbl[i].e_sum});
                chk("tbl_tag_ok", {31'b0, out_tag_ok}, {31'b0, tbl[i].e_ok});
            end
        end

        // ---- fill to full, overflow, drain in order ----
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hFFFF_0000 | i, 1'b0, 1'b0);
        chk("full_level", {28'b0, level}, 32'd8);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        cycle(1'b1, 32'hFFFF_0099, 1'b1 & 1'b0, 1'b0);
        chk("overflow_drop", {31'b0, drop}, 32'd1);
        chk("overflow_level", {28'b0, level}, 32'd8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained_out_valid", {31'b0, out_valid}, 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // ---- streaming from empty with pointer wrap ----
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'hFFFF_0100 + i, 1'b1, 1'b0);
            chk("stream_level", {28'b0, level}, 32'd1);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // ---- bad-tag saturation ----
        for (int i = 0; i < 300; i++) cycle(1'b1, {16'h1234, 16'(i)}, 1'b1, 1'b0);
        chk("err_saturated", {24'b0, err_count}, 32'hFF);

        // ---- clr priority over concurrent write/read ----
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            cycle(1'b1, (i < 3) ? (32'h0000_0000 | i) : (32'hFFFF_0000 | i), 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFF_00EE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("preclr_level", {28'b0, level}, 32'd5);
        chk("preclr_err", {24'b0, err_count}, 32'd3);
        chk("preclr_drop", {31'b0, drop}, 32'd1);
        cycle(1'b1, 32'hFFFF_7777, 1'b1, 1'b1);
        chk("clr_level", {28'b0, level}, 32'd0);
        chk("clr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("clr_in_ready", {31'b0, in_ready}, 32'd1);

        // ---- asynchronous reset between edges ----
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hFFFF_0A00 | i, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_in_ready", {31'b0, in_ready}, 32'd1);
        chk("async_level", {28'b0, level}, 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'hFFFF_BEEF, 1'b0, 1'b0);
        chk("post_reset_sum", {16'b0, out_sum}, 32'h0000_BEEF);
        chk("post_reset_tag_ok", {31'b0, out_tag_ok}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++) begin
            logic [15:0] tag;
            tag = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
            cycle(1'($urandom_range(0, 1)), {tag, 16'($urandom)},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
